rv_alu_pipe: RTL and testbench

// - Three-stage execute pipeline of the multi-cycle RV32I core, between decode/register-read and memory/write-back.
// - Stage 1 latches the decoded instruction and register operands and selects the ALU operands.
// - Stage 2 computes the ALU result, branch comparison, memory address and jump target.
// - Stage 3 resolves branch/jump redirection and aligns store data and byte enables for the Wishbone port.

---
 rtl/rv_alu_pkg.sv | 86 ++++++++
 rtl/rv_alu_core.sv | 28 ++
 rtl/rv_alu_pipe.sv | 157 +++++++++++++++
 tb/tb_rv_alu_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_alu_pkg.sv
// Shared types for the RV32I execute pipeline: ALU op encoding, result-source
// one-hot, funct3 constants and the per-stage register layouts.
package rv_alu_pkg;
  localparam int DW = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic pc_p4;
    logic mem;
    logic alu;
  } res_src_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic          compressed;
    logic [4:0]    rd;
    logic [DW-1:0] imm;
    logic [2:0]    funct3;
    logic [3:0]    alu_op;
    logic          branch;
    logic          jump;
    logic          jalr;
    logic          store;
    logic          reg_write;
    res_src_t      res_src;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
  } s1_t;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic          compressed;
    logic [4:0]    rd;
    logic [2:0]    funct3;
    logic          branch;
    logic          jump;
    logic          store;
    logic          reg_write;
    res_src_t      res_src;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] add;
    logic [DW-1:0] target;
    logic          cond;
    logic [DW-1:0] rs2;
  } s2_t;

  typedef struct packed {
    logic [DW-1:0] alu_result;
    logic [DW-1:0] add;
    logic [DW-1:0] pc_target;
    logic          pc_select;
    logic [DW-1:0] wdata;
    logic [3:0]    wsel;
    logic [DW-1:0] pc;
    logic [2:0]    funct3;
    logic [4:0]    rd;
    logic          reg_write;
    res_src_t      res_src;
    logic          store;
    logic          compressed;
  } s3_t;
endpackage

// File: rtl/rv_alu_core.sv
// Combinational RV32I integer ALU; unknown op codes fall back to ADD.
module rv_alu_core
  import rv_alu_pkg::*;
(
  input  logic [DW-1:0] i_op1,
  input  logic [DW-1:0] i_op2,
  input  logic [3:0]    i_alu_op,
  output logic [DW-1:0] o_result
);
  logic [4:0] shamt;
  assign shamt = i_op2[4:0];

  always_comb begin
    o_result = i_op1 + i_op2;
    case (i_alu_op)
      ALU_SUB:  o_result = i_op1 - i_op2;
      ALU_SLL:  o_result = i_op1 << shamt;
      ALU_SLT:  o_result = {{(DW-1){1'b0}}, $signed(i_op1) < $signed(i_op2)};
      ALU_SLTU: o_result = {{(DW-1){1'b0}}, i_op1 < i_op2};
      ALU_XOR:  o_result = i_op1 ^ i_op2;
      ALU_SRL:  o_result = i_op1 >> shamt;
      ALU_SRA:  o_result = $signed(i_op1) >>> shamt;
      ALU_OR:   o_result = i_op1 | i_op2;
      ALU_AND:  o_result = i_op1 & i_op2;
      default:  o_result = i_op1 + i_op2;
    endcase
  end
endmodule

// File: rtl/rv_alu_pipe.sv
// Three-stage RV32I execute pipeline: operand select, ALU/compare/address,
// then redirect resolution and Wishbone store-lane alignment.
module rv_alu_pipe
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_compressed,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_imm,
  input  logic [2:0]      i_funct3,
  input  logic [3:0]      i_alu_op,
  input  logic            i_op1_pc,
  input  logic            i_op1_zero,
  input  logic            i_op2_imm,
  input  logic            i_branch,
  input  logic            i_jump,
  input  logic            i_jalr,
  input  logic            i_store,
  input  logic            i_reg_write,
  input  logic [2:0]      i_res_src,
  input  logic [XLEN-1:0] i_reg1_data,
  input  logic [XLEN-1:0] i_reg2_data,
  output logic [XLEN-1:0] o_alu_result,
  output logic [XLEN-1:0] o_add,
  output logic [XLEN-1:0] o_pc_target,
  output logic            o_pc_select,
  output logic [XLEN-1:0] o_wdata,
  output logic [3:0]      o_wsel,
  output logic [XLEN-1:0] o_pc,
  output logic [2:0]      o_funct3,
  output logic [4:0]      o_rd,
  output logic            o_reg_write,
  output logic [2:0]      o_res_src,
  output logic            o_store,
  output logic            o_compressed
);
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] rs1_imm;

  always_comb begin
    s1_d            = '0;
    s1_d.pc         = i_pc;
    s1_d.compressed = i_compressed;
    s1_d.rd         = i_rd;
    s1_d.imm        = i_imm;
    s1_d.funct3     = i_funct3;
    s1_d.alu_op     = i_alu_op;
    s1_d.branch     = i_branch;
    s1_d.jump       = i_jump;
    s1_d.jalr       = i_jalr;
    s1_d.store      = i_store;
    s1_d.reg_write  = i_reg_write;
    s1_d.res_src    = res_src_t'(i_res_src);
    s1_d.op1        = i_op1_pc ? i_pc : (i_op1_zero ? '0 : i_reg1_data);
    s1_d.op2        = i_op2_imm ? i_imm : i_reg2_data;
    s1_d.rs1        = i_reg1_data;
    s1_d.rs2        = i_reg2_data;
  end

  rv_alu_core u_core (
    .i_op1    (s1_q.op1),
    .i_op2    (s1_q.op2),
    .i_alu_op (s1_q.alu_op),
    .o_result (alu_res)
  );

  assign rs1_imm = s1_q.rs1 + s1_q.imm;

  always_comb begin
    s2_d            = '0;
    s2_d.pc         = s1_q.pc;
    s2_d.compressed = s1_q.compressed;
    s2_d.rd         = s1_q.rd;
    s2_d.funct3     = s1_q.funct3;
    s2_d.branch     = s1_q.branch;
    s2_d.jump       = s1_q.jump;
    s2_d.store      = s1_q.store;
    s2_d.reg_write  = s1_q.reg_write;
    s2_d.res_src    = s1_q.res_src;
    s2_d.alu_result = alu_res;
    s2_d.add        = rs1_imm;
    s2_d.rs2        = s1_q.rs2;
    // JALR clears bit 0 of the computed target
    s2_d.target     = s1_q.jalr ? {rs1_imm[DW-1:1], 1'b0} : s1_q.pc + s1_q.imm;
    case (s1_q.funct3)
      F3_BEQ:  s2_d.cond = s1_q.rs1 == s1_q.rs2;
      F3_BNE:  s2_d.cond = s1_q.rs1 != s1_q.rs2;
      F3_BLT:  s2_d.cond = $signed(s1_q.rs1) <  $signed(s1_q.rs2);
      F3_BGE:  s2_d.cond = $signed(s1_q.rs1) >= $signed(s1_q.rs2);
      F3_BLTU: s2_d.cond = s1_q.rs1 <  s1_q.rs2;
      F3_BGEU: s2_d.cond = s1_q.rs1 >= s1_q.rs2;
      default: s2_d.cond = 1'b0;
    endcase
  end

  always_comb begin
    s3_d            = '0;
    s3_d.alu_result = s2_q.alu_result;
    s3_d.add        = s2_q.add;
    s3_d.pc_target  = s2_q.target;
    s3_d.pc_select  = s2_q.jump | (s2_q.branch & s2_q.cond);
    s3_d.pc         = s2_q.pc;
    s3_d.funct3     = s2_q.funct3;
    s3_d.rd         = s2_q.rd;
    s3_d.reg_write  = s2_q.reg_write;
    s3_d.res_src    = s2_q.res_src;
    s3_d.store      = s2_q.store;
    s3_d.compressed = s2_q.compressed;
    case (s2_q.funct3[1:0])
      W_BYTE: begin
        s3_d.wdata = {4{s2_q.rs2[7:0]}};
        s3_d.wsel  = 4'b0001 << s2_q.add[1:0];
      end
      W_HALF: begin
        s3_d.wdata = {2{s2_q.rs2[15:0]}};
        s3_d.wsel  = 4'b0011 << {s2_q.add[1], 1'b0};
      end
      default: begin
        s3_d.wdata = s2_q.rs2;
        s3_d.wsel  = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign o_alu_result = s3_q.alu_result;
  assign o_add        = s3_q.add;
  assign o_pc_target  = s3_q.pc_target;
  assign o_pc_select  = s3_q.pc_select;
  assign o_wdata      = s3_q.wdata;
  assign o_wsel       = s3_q.wsel;
  assign o_pc         = s3_q.pc;
  assign o_funct3     = s3_q.funct3;
  assign o_rd         = s3_q.rd;
  assign o_reg_write  = s3_q.reg_write;
  assign o_res_src    = s3_q.res_src;
  assign o_store      = s3_q.store;
  assign o_compressed = s3_q.compressed;
endmodule

// File: tb/tb_rv_alu_pipe.sv
// Bench for rv_alu_pipe: an instruction-level model predicts every output
// cycle, and directed vectors pin the model with hand-computed values.
module tb_rv_alu_pipe;
  typedef struct packed {
    logic [31:0] pc;
    logic        compressed;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        op1_pc, op1_zero, op2_imm;
    logic        branch, jump, jalr, store, reg_write;
    logic [2:0]  res_src;
    logic [31:0] rs1, rs2;
  } in_t;

  typedef struct packed {
    logic [31:0] alu, add, tgt;
    logic        sel;
    logic [31:0] wdata;
    logic [3:0]  wsel;
    logic [31:0] pc;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic [2:0]  res_src;
    logic        store, compressed;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  in_t  vin;
  localparam in_t NOP = '0;

  logic [31:0] o_alu_result, o_add, o_pc_target, o_wdata, o_pc;
  logic        o_pc_select, o_reg_write, o_store, o_compressed;
  logic [3:0]  o_wsel;
  logic [2:0]  o_funct3, o_res_src;
  logic [4:0]  o_rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rv_alu_pipe #(.XLEN(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_pc(vin.pc), .i_compressed(vin.compressed),
    .i_rd(vin.rd), .i_imm(vin.imm), .i_funct3(vin.funct3), .i_alu_op(vin.alu_op),
    .i_op1_pc(vin.op1_pc), .i_op1_zero(vin.op1_zero), .i_op2_imm(vin.op2_imm),
    .i_branch(vin.branch), .i_jump(vin.jump), .i_jalr(vin.jalr), .i_store(vin.store),
    .i_reg_write(vin.reg_write), .i_res_src(vin.res_src),
    .i_reg1_data(vin.rs1), .i_reg2_data(vin.rs2),
    .o_alu_result(o_alu_result), .o_add(o_add), .o_pc_target(o_pc_target),
    .o_pc_select(o_pc_select), .o_wdata(o_wdata), .o_wsel(o_wsel), .o_pc(o_pc),
    .o_funct3(o_funct3), .o_rd(o_rd), .o_reg_write(o_reg_write),
    .o_res_src(o_res_src), .o_store(o_store), .o_compressed(o_compressed)
  );

  function automatic out_t model(input in_t v);
    out_t o;
    logic [31:0] a, b;
    int sh;
    logic take;
    o = '0;
    a = v.op1_pc ? v.pc : (v.op1_zero ? 32'd0 : v.rs1);
    b = v.op2_imm ? v.imm : v.rs2;
    sh = int'(b % 32);
    case (v.alu_op)
      4'd1: o.alu = a - b;
      4'd2: o.alu = a << sh;
      4'd3: o.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: o.alu = (a < b) ? 32'd1 : 32'd0;
      4'd5: o.alu = a ^ b;
      4'd6: o.alu = a >> sh;
      4'd7: o.alu = $signed(a) >>> sh;
      4'd8: o.alu = a | b;
      4'd9: o.alu = a & b;
      default: o.alu = a + b;
    endcase
    o.add = v.rs1 + v.imm;
    o.tgt = v.jalr ? (o.add & 32'hFFFF_FFFE) : v.pc + v.imm;
    case (v.funct3)
      3'd0: take = v.rs1 == v.rs2;
      3'd1: take = v.rs1 != v.rs2;
      3'd4: take = $signed(v.rs1) < $signed(v.rs2);
      3'd5: take = !($signed(v.rs1) < $signed(v.rs2));
      3'd6: take = v.rs1 < v.rs2;
      3'd7: take = !(v.rs1 < v.rs2);
      default: take = 1'b0;
    endcase
    o.sel = v.jump || (v.branch && take);
    case (v.funct3[1:0])
      2'd0: begin o.wdata = {4{v.rs2[7:0]}};  o.wsel = 4'(1 << o.add[1:0]); end
      2'd1: begin o.wdata = {2{v.rs2[15:0]}}; o.wsel = o.add[1] ? 4'b1100 : 4'b0011; end
      default: begin o.wdata = v.rs2; o.wsel = 4'b1111; end
    endcase
    o.pc = v.pc; o.funct3 = v.funct3; o.rd = v.rd; o.reg_write = v.reg_write;
    o.res_src = v.res_src; o.store = v.store; o.compressed = v.compressed;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Output after edge k is the model of the instruction sampled at edge k-2;
  // a reset edge shows zeros, then drains instructions that were all-zero.
  out_t cur, d1, d2;
  logic chk_en = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      cur <= '0; d1 <= model(NOP); d2 <= model(NOP); chk_en <= 1'b1;
    end else begin
      cur <= d2; d2 <= d1; d1 <= model(vin);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_alu", o_alu_result, cur.alu);
      chk("m_add", o_add, cur.add);
      chk("m_tgt", o_pc_target, cur.tgt);
      chk("m_sel", 32'(o_pc_select), 32'(cur.sel));
      chk("m_wdata", o_wdata, cur.wdata);
      chk("m_wsel", 32'(o_wsel), 32'(cur.wsel));
      chk("m_pc", o_pc, cur.pc);
      chk("m_pass", {o_funct3, o_rd, o_reg_write, o_res_src, o_store, o_compressed},
          {cur.funct3, cur.rd, cur.reg_write, cur.res_src, cur.store, cur.compressed});
    end
  end

  // Drive one instruction followed by bubbles; returns at the sample point
  // where that instruction's results are on the outputs.
  task automatic send(input in_t v);
    @(negedge clk); vin = v;
    @(negedge clk); vin = NOP;
    @(negedge clk);
    @(negedge clk);
  endtask

  in_t v;
  initial begin
    rst = 1'b1; vin = NOP;
    repeat (2) @(negedge clk);
    chk("rst_alu", o_alu_result, 32'd0);
    chk("rst_ctl", {o_pc_select, o_reg_write, o_store, o_res_src, o_wsel}, '0);
    rst = 1'b0;

    v = NOP; v.rs1 = 32'd5; v.imm = 32'hFFFF_FFFD; v.op2_imm = 1; v.reg_write = 1;
    v.res_src = 3'b001;
    send(v);
    chk("add_res", o_alu_result, 32'd2);
    chk("add_rw", 32'(o_reg_write), 32'd1);

    v = NOP; v.rs1 = 32'h8000_0000; v.rs2 = 32'd4; v.alu_op = 4'd7;
    send(v);
    chk("sra", o_alu_result, 32'hF800_0000);
    v.rs2 = 32'd1; v.alu_op = 4'd4;
    send(v);
    chk("sltu", o_alu_result, 32'd0);

    v = NOP; v.rs1 = 32'hFFFF_FFFF; v.rs2 = 32'd1; v.pc = 32'h100; v.imm = 32'h20;
    v.branch = 1; v.funct3 = 3'b100;
    send(v);
    chk("blt_sel", 32'(o_pc_select), 32'd1);
    chk("blt_tgt", o_pc_target, 32'h120);
    v.funct3 = 3'b110;
    send(v);
    chk("bltu_sel", 32'(o_pc_select), 32'd0);

    v = NOP; v.rs1 = 32'h1003; v.imm = 32'd2; v.jump = 1; v.jalr = 1;
    send(v);
    chk("jalr_tgt", o_pc_target, 32'h1004);
    chk("jalr_sel", 32'(o_pc_select), 32'd1);

    v = NOP; v.rs1 = 32'h2001; v.rs2 = 32'hAB; v.store = 1; v.funct3 = 3'b000;
    send(v);
    chk("sb_add", o_add, 32'h2001);
    chk("sb_wsel", 32'(o_wsel), 32'b0010);
    chk("sb_wdata", o_wdata, 32'hABAB_ABAB);
    v.rs1 = 32'h2002; v.rs2 = 32'h1234_5678; v.funct3 = 3'b001;
    send(v);
    chk("sh_wsel", 32'(o_wsel), 32'b1100);
    chk("sh_wdata", o_wdata, 32'h5678_5678);

    // back-to-back sweep over every op code and operand source
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vin = NOP; vin.alu_op = 4'(i); vin.rs1 = 32'h8765_4321 ^ (i * 32'h0101_0101);
      vin.rs2 = 32'(i * 3 + 1); vin.imm = 32'hFFFF_FF00 | 32'(i * 7);
      vin.op2_imm = i[0]; vin.op1_pc = (i % 5 == 0); vin.op1_zero = (i % 3 == 0);
      vin.pc = 32'h400 + 32'(i * 4); vin.rd = 5'(i); vin.compressed = i[1];
      vin.res_src = 3'(1 << (i % 3)); vin.reg_write = i[2];
    end
    // every funct3 against equal, signed-less and unsigned-less operand pairs
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      vin = NOP; vin.branch = 1; vin.funct3 = 3'(i % 8); vin.pc = 32'h800;
      vin.imm = 32'(i * 4); vin.jump = (i == 23); vin.jalr = (i == 23);
      vin.store = i[0]; vin.rs1 = (i / 8 == 0) ? 32'h55 : ((i / 8 == 1) ? 32'hFFFF_FFF0 : 32'h3);
      vin.rs2 = (i / 8 == 0) ? 32'h55 : 32'h7 + 32'(i);
    end

    // reset while instructions are in flight
    @(negedge clk);
    vin = NOP; vin.rs1 = 32'h33; vin.rs2 = 32'h44; vin.store = 1; vin.reg_write = 1;
    vin.jump = 1; vin.res_src = 3'b010; vin.pc = 32'h900;
    @(negedge clk); vin.rs1 = 32'h66;
    @(negedge clk); rst = 1'b1; vin.rs1 = 32'h77;
    @(negedge clk); rst = 1'b0; vin = NOP;
    chk("mid_rst_alu", o_alu_result, 32'd0);
    chk("mid_rst_pc", o_pc, 32'd0);
    chk("mid_rst_ctl", {o_pc_select, o_reg_write, o_store, o_res_src, o_wsel}, '0);
    v = NOP; v.rs1 = 32'd5; v.imm = 32'hFFFF_FFFD; v.op2_imm = 1; v.reg_write = 1;
    send(v);
    chk("refill_res", o_alu_result, 32'd2);
    chk("refill_rw", 32'(o_reg_write), 32'd1);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
